// File: rtl/conware_pkg.sv
// Shared definitions for the conware row scheduler and its generation core.
// Contents:
//   sched_state_t          - scheduler state encoding
//   clog2_min1()           - counter width helper (never below 1 bit)
//   BEAT_W / ROW_W         - counter widths for the default 32x32 frame
//   COLOUR_ALIVE/DEAD      - pixel colours understood by the core
package conware_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RECIRC = 3'd2,
    EMIT   = 3'd3,
    BYPASS = 3'd4,
    FIN    = 3'd5
  } sched_state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_HEIGHT = 32;

  // Width of a counter that must hold 0..n-1; a 1-entry range still needs a bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_W = clog2_min1(DEF_WIDTH);
  localparam int ROW_W  = clog2_min1(DEF_HEIGHT);

  localparam logic [31:0] COLOUR_ALIVE = 32'h00FF_FFFF;
  localparam logic [31:0] COLOUR_DEAD  = 32'h0000_0000;

endpackage

// File: rtl/axis_beat_counter.sv
// Beat position counter for one AXI-Stream row transfer.
// Ports:
//   i_clk, i_rst_n  - clock, synchronous active-low reset
//   i_fire          - a beat transferred this cycle
//   i_clear         - force the count back to beat 0
//   o_count         - index of the next beat (0..WIDTH-1)
//   o_last_beat     - next beat is the final beat of the row
import conware_pkg::*;

module axis_beat_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = clog2_min1(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fire,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last_beat
);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last      = (r_count == CNT_W'(WIDTH - 1));
  assign o_count     = r_count;
  assign o_last_beat = w_last;

  // Advance on every transferred beat, wrapping after the last beat of a row.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_fire) begin
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/conware_row_sched.sv
// Row sequencer around the conware generation core.
// Seed rows arrive on S_AXIS and are loaded into the core on C_AXIS; the core
// result (R_AXIS) is fed back into the core until num_gens generations have
// been applied, then the row goes out on M_AXIS. num_gens == 0 routes S
// straight to M. HEIGHT rows make a frame; done pulses when the frame is out.
// Ports:
//   ACLK, ARESETN          - clock, synchronous active-low reset
//   start, num_gens        - frame launch and generations per row
//   busy, done, err        - frame status; err flags upstream TLAST misplacement
//   S/C/R/M_AXIS_*         - seed in, core in, core out, result out
// Optional build macro CONWARE_SCHED_STATS_EN adds stat_cycles/stat_stalls.
module conware_row_sched
  import conware_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int GEN_BITS = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic [GEN_BITS-1:0] num_gens,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  input  logic [DWIDTH-1:0]   S_AXIS_TDATA,
  input  logic                S_AXIS_TLAST,
  output logic                C_AXIS_TVALID,
  input  logic                C_AXIS_TREADY,
  output logic [DWIDTH-1:0]   C_AXIS_TDATA,
  output logic                C_AXIS_TLAST,
  input  logic                R_AXIS_TVALID,
  output logic                R_AXIS_TREADY,
  input  logic [DWIDTH-1:0]   R_AXIS_TDATA,
  input  logic                R_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic [DWIDTH-1:0]   M_AXIS_TDATA,
  output logic                M_AXIS_TLAST
`ifdef CONWARE_SCHED_STATS_EN
  ,
  output logic [31:0]         stat_cycles,
  output logic [31:0]         stat_stalls
`endif
);

  localparam int L_BEAT_W = clog2_min1(WIDTH);
  localparam int L_ROW_W  = clog2_min1(HEIGHT);

  sched_state_t          r_state;
  logic [GEN_BITS-1:0]   r_gens_cfg;
  logic [GEN_BITS-1:0]   r_gen_cnt;
  logic [L_ROW_W-1:0]    r_row_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_act_valid;
  logic                  w_act_ready;
  logic                  w_up_last;
  logic                  w_fire;
  logic                  w_last_beat;
  logic                  w_row_end;
  logic                  w_clear;
  logic                  w_last_row;
  logic [L_BEAT_W-1:0]   w_beat_cnt;

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

  assign w_fire     = w_act_valid & w_act_ready;
  assign w_row_end  = w_fire & w_last_beat;
  assign w_clear    = (r_state == IDLE) || (r_state == FIN);
  assign w_last_row = (r_row_cnt == L_ROW_W'(HEIGHT - 1));

  axis_beat_counter #(
    .WIDTH (WIDTH),
    .CNT_W (L_BEAT_W)
  ) u_beat_cnt (
    .i_clk       (ACLK),
    .i_rst_n     (ARESETN),
    .i_fire      (w_fire),
    .i_clear     (w_clear),
    .o_count     (w_beat_cnt),
    .o_last_beat (w_last_beat)
  );

  // Path routing: the state alone picks source and sink; everything else idles at 0.
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    R_AXIS_TREADY = 1'b0;
    C_AXIS_TVALID = 1'b0;
    C_AXIS_TDATA  = '0;
    C_AXIS_TLAST  = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    w_act_valid   = 1'b0;
    w_act_ready   = 1'b0;
    w_up_last     = 1'b0;
    case (r_state)
      LOAD: begin
        C_AXIS_TVALID = S_AXIS_TVALID;
        C_AXIS_TDATA  = S_AXIS_TDATA;
        C_AXIS_TLAST  = w_last_beat;
        S_AXIS_TREADY = C_AXIS_TREADY;
        w_act_valid   = S_AXIS_TVALID;
        w_act_ready   = C_AXIS_TREADY;
        w_up_last     = S_AXIS_TLAST;
      end
      RECIRC: begin
        C_AXIS_TVALID = R_AXIS_TVALID;
        C_AXIS_TDATA  = R_AXIS_TDATA;
        C_AXIS_TLAST  = w_last_beat;
        R_AXIS_TREADY = C_AXIS_TREADY;
        w_act_valid   = R_AXIS_TVALID;
        w_act_ready   = C_AXIS_TREADY;
        w_up_last     = R_AXIS_TLAST;
      end
      EMIT: begin
        M_AXIS_TVALID = R_AXIS_TVALID;
        M_AXIS_TDATA  = R_AXIS_TDATA;
        M_AXIS_TLAST  = w_last_beat;
        R_AXIS_TREADY = M_AXIS_TREADY;
        w_act_valid   = R_AXIS_TVALID;
        w_act_ready   = M_AXIS_TREADY;
        w_up_last     = R_AXIS_TLAST;
      end
      BYPASS: begin
        M_AXIS_TVALID = S_AXIS_TVALID;
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TLAST  = w_last_beat;
        S_AXIS_TREADY = M_AXIS_TREADY;
        w_act_valid   = S_AXIS_TVALID;
        w_act_ready   = M_AXIS_TREADY;
        w_up_last     = S_AXIS_TLAST;
      end
      default: begin
      end
    endcase
  end

  // Frame sequencer: path changes only on the last beat of a row, so stalls just hold.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state    <= IDLE;
      r_gens_cfg <= '0;
      r_gen_cnt  <= '0;
      r_row_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Upstream framing is only checked, never trusted; the beat still goes through.
      if (w_fire && (w_up_last != (w_beat_cnt == L_BEAT_W'(WIDTH - 1)))) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_gens_cfg <= num_gens;
            r_gen_cnt  <= '0;
            r_row_cnt  <= '0;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_state    <= (num_gens != '0) ? LOAD : BYPASS;
          end
        end
        LOAD: begin
          if (w_row_end) begin
            r_gen_cnt <= GEN_BITS'(1);
            r_state   <= (r_gens_cfg > GEN_BITS'(1)) ? RECIRC : EMIT;
          end
        end
        RECIRC: begin
          if (w_row_end) begin
            r_gen_cnt <= r_gen_cnt + GEN_BITS'(1);
            // The pass that is finishing now is generation r_gen_cnt+1.
            if (r_gen_cnt == r_gens_cfg - GEN_BITS'(1)) begin
              r_state <= EMIT;
            end
          end
        end
        EMIT, BYPASS: begin
          if (w_row_end) begin
            r_row_cnt <= r_row_cnt + L_ROW_W'(1);
            if (w_last_row) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= (r_state == EMIT) ? LOAD : BYPASS;
            end
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef CONWARE_SCHED_STATS_EN
  logic [31:0] r_stat_cycles;
  logic [31:0] r_stat_stalls;

  assign stat_cycles = r_stat_cycles;
  assign stat_stalls = r_stat_stalls;

  // Frame statistics: cleared by an accepted start, frozen once the frame reaches FIN.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_stat_cycles <= 32'd0;
      r_stat_stalls <= 32'd0;
    end else if ((r_state == IDLE) && start) begin
      r_stat_cycles <= 32'd0;
      r_stat_stalls <= 32'd0;
    end else if (r_busy && (r_state != FIN)) begin
      if (r_stat_cycles != 32'hFFFF_FFFF) begin
        r_stat_cycles <= r_stat_cycles + 32'd1;
      end
      if (w_act_valid && !w_act_ready && (r_stat_stalls != 32'hFFFF_FFFF)) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end else begin
      r_stat_cycles <= r_stat_cycles;
      r_stat_stalls <= r_stat_stalls;
    end
  end
`endif

endmodule

// File: tb/tb_conware_row_sched.sv
// Scoreboard bench for conware_row_sched (WIDTH=4, HEIGHT=2).
// A small core model inverts colour (XOR with alive^dead) on every pass.
module tb_conware_row_sched;
  import conware_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam logic [31:0] INV = COLOUR_ALIVE ^ COLOUR_DEAD;
  localparam logic [31:0] SEEDS [W*H] = '{COLOUR_ALIVE, COLOUR_DEAD, COLOUR_ALIVE, COLOUR_ALIVE,
                                          COLOUR_DEAD, COLOUR_DEAD, 32'h0000_00A5, 32'h0012_3456};

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_gens = 16'd0;
  logic        busy, done, err;
  logic        S_AXIS_TVALID = 1'b0, S_AXIS_TLAST = 1'b0;
  logic [31:0] S_AXIS_TDATA = 32'd0;
  logic        S_AXIS_TREADY;
  logic        C_AXIS_TVALID, C_AXIS_TLAST;
  logic        C_AXIS_TREADY = 1'b1;
  logic [31:0] C_AXIS_TDATA;
  logic        R_AXIS_TVALID = 1'b0, R_AXIS_TLAST = 1'b0;
  logic [31:0] R_AXIS_TDATA = 32'd0;
  logic        R_AXIS_TREADY;
  logic        M_AXIS_TVALID, M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b1;
  logic [31:0] M_AXIS_TDATA;

  always #5 ACLK = ~ACLK;

  conware_row_sched #(.DWIDTH(32), .WIDTH(W), .HEIGHT(H), .GEN_BITS(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .num_gens(num_gens),
    .busy(busy), .done(done), .err(err),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TLAST(S_AXIS_TLAST),
    .C_AXIS_TVALID(C_AXIS_TVALID), .C_AXIS_TREADY(C_AXIS_TREADY),
    .C_AXIS_TDATA(C_AXIS_TDATA), .C_AXIS_TLAST(C_AXIS_TLAST),
    .R_AXIS_TVALID(R_AXIS_TVALID), .R_AXIS_TREADY(R_AXIS_TREADY),
    .R_AXIS_TDATA(R_AXIS_TDATA), .R_AXIS_TLAST(R_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST)
  );

  logic [32:0] seed_q [$];   // {tlast, data} waiting on S_AXIS
  logic [31:0] core_q [$];   // core model output buffer
  logic [32:0] exp_q  [$];   // expected {tlast, data} on M_AXIS

  int n_checks = 0;
  int n_pass = 0;
  int s_stall = 0;
  int m_stall = 0;
  int c_beats = 0;
  int m_beats = 0;
  int c_valid_cyc = 0;
  int core_out = 0;
  logic s_fire_n = 1'b0, c_fire_n = 1'b0, r_fire_n = 1'b0, m_fire_n = 1'b0;
  logic [31:0] c_data_n = 32'd0;
  logic prev_final = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // Monitor: sample handshakes that will complete at the next rising edge and score M beats.
  always @(negedge ACLK) begin
    logic [32:0] e;
    logic final_now;
    final_now = 1'b0;
    s_fire_n = ARESETN && S_AXIS_TVALID && S_AXIS_TREADY;
    c_fire_n = ARESETN && C_AXIS_TVALID && C_AXIS_TREADY;
    r_fire_n = ARESETN && R_AXIS_TVALID && R_AXIS_TREADY;
    m_fire_n = ARESETN && M_AXIS_TVALID && M_AXIS_TREADY;
    c_data_n = C_AXIS_TDATA;
    if (C_AXIS_TVALID) c_valid_cyc++;
    if (c_fire_n) begin
      c_beats++;
      chk("c_tlast", 32'(C_AXIS_TLAST), 32'((c_beats % W) == 0));
    end
    if (m_fire_n) begin
      m_beats++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL m_extra_beat: got data 0x%08h, expected no beat", M_AXIS_TDATA);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", M_AXIS_TDATA, e[31:0]);
        chk("m_tlast", 32'(M_AXIS_TLAST), 32'(e[32]));
        final_now = M_AXIS_TLAST && (exp_q.size() == 0);
      end
    end
    if (done || prev_final) chk("done_pulse", 32'(done), 32'(prev_final));
    prev_final = final_now;
  end

  // Drivers: apply completed transfers, run the core model, present next beats.
  always @(posedge ACLK) begin
    #1;
    if (s_fire_n) void'(seed_q.pop_front());
    if (r_fire_n) begin
      void'(core_q.pop_front());
      core_out++;
    end
    if (c_fire_n) core_q.push_back(c_data_n ^ INV);
    S_AXIS_TVALID = (seed_q.size() > 0) && (int'($urandom_range(99)) >= s_stall);
    {S_AXIS_TLAST, S_AXIS_TDATA} = (seed_q.size() > 0) ? seed_q[0] : 33'd0;
    R_AXIS_TVALID = (core_q.size() > 0);
    R_AXIS_TDATA  = (core_q.size() > 0) ? core_q[0] : 32'd0;
    R_AXIS_TLAST  = ((core_out % W) == W - 1);
    M_AXIS_TREADY = (int'($urandom_range(99)) >= m_stall);
  end

  task automatic load_frame(input int gens, input int tag, input bit bad_last);
    logic [31:0] d;
    logic lst;
    c_beats = 0;
    m_beats = 0;
    c_valid_cyc = 0;
    for (int i = 0; i < W*H; i++) begin
      d = SEEDS[i] | (32'(tag) << 24);
      lst = (bad_last && i < W) ? (i == 2) : ((i % W) == W - 1);
      seed_q.push_back({lst, d});
      exp_q.push_back({((i % W) == W - 1), ((gens % 2) == 1) ? (d ^ INV) : d});
    end
  endtask

  task automatic pulse_start(input int gens);
    @(posedge ACLK); #1;
    start = 1'b1;
    num_gens = 16'(gens);
    @(posedge ACLK); #1;
    start = 1'b0;
    @(negedge ACLK);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_after_start", 32'(err), 32'd0);
  endtask

  task automatic run_frame(input int gens, input int tag, input bit bad_last,
                           input int sst, input int mst, input bit poke);
    int t;
    s_stall = sst;
    m_stall = mst;
    load_frame(gens, tag, bad_last);
    pulse_start(gens);
    if (poke) begin
      @(posedge ACLK); #1;
      start = 1'b1;
      num_gens = 16'd0;
      @(posedge ACLK); #1;
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge ACLK);
      t++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("m_beat_count", 32'(m_beats), 32'(W*H));
    chk("c_beat_count", 32'(c_beats), 32'(W*H*gens));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    @(negedge ACLK);
    chk("busy_after_done", 32'(busy), 32'd0);
    s_stall = 0;
    m_stall = 0;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_handshakes", {28'd0, S_AXIS_TREADY, C_AXIS_TVALID, R_AXIS_TREADY, M_AXIS_TVALID}, 32'd0);
    @(posedge ACLK); #2;
    ARESETN = 1'b1;

    run_frame(0, 1, 1'b0, 0, 0, 1'b0);
    chk("bypass_c_valid_cycles", 32'(c_valid_cyc), 32'd0);
    run_frame(1, 2, 1'b0, 0, 0, 1'b0);
    run_frame(3, 3, 1'b0, 0, 0, 1'b1);
    run_frame(2, 4, 1'b0, 50, 50, 1'b0);
    chk("err_before_bad_frame", 32'(err), 32'd0);
    run_frame(1, 5, 1'b1, 0, 0, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    run_frame(0, 6, 1'b0, 0, 0, 1'b0);
    chk("err_after_clean_frame", 32'(err), 32'd0);

    // Abort a frame with reset while it is recirculating.
    load_frame(3, 7, 1'b0);
    pulse_start(3);
    t = 0;
    while (c_beats < 6 && t < 500) begin
      @(negedge ACLK);
      t++;
    end
    chk("reset_point_reached", 32'(c_beats >= 6), 32'd1);
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_c_valid", 32'(C_AXIS_TVALID), 32'd0);
    chk("abort_r_ready", 32'(R_AXIS_TREADY), 32'd0);
    chk("abort_s_ready", 32'(S_AXIS_TREADY), 32'd0);
    chk("abort_m_valid", 32'(M_AXIS_TVALID), 32'd0);
    seed_q.delete();
    core_q.delete();
    exp_q.delete();
    core_out = 0;
    @(posedge ACLK); #2;
    ARESETN = 1'b1;
    run_frame(2, 8, 1'b0, 0, 0, 1'b0);

    repeat (3) @(posedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conware_row_sched.md
Name: conware_row_sched

Overview:
- Sequencer wrapped around the conware generation core.
- Takes seed rows from DMA (S_AXIS) and loads one row at a time into the core.
- Recirculates the core result back into the core until num_gens generations are done, then emits the final row to DMA (M_AXIS).
- Repeats for HEIGHT rows per frame, then signals done.

Parameters:
- DWIDTH, 32, pixel/beat data width (one pixel per beat).
- WIDTH, 32, pixels per row; beats per row transfer.
- HEIGHT, 32, rows per frame.
- GEN_BITS, 16, width of generation count/config.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, synchronous, active-low.
- start  in  1  pulse; latches num_gens and begins a frame (ignored when busy=1).
- num_gens  in  GEN_BITS  generations applied per row; 0 = bypass.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after last beat of last row accepted on M_AXIS.
- err  out  1  sticky: upstream TLAST disagreed with beat count; cleared by start.
- S_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/DWIDTH/1  seed stream from DMA.
- C_AXIS_TVALID/TREADY/TDATA/TLAST  out/in/out/out  1/1/DWIDTH/1  to core input.
- R_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/DWIDTH/1  from core output.
- M_AXIS_TVALID/TREADY/TDATA/TLAST  out/in/out/out  1/1/DWIDTH/1  result stream to DMA.

Behaviour:
- Reset (ARESETN=0 at ACLK edge): state IDLE; all counters 0; busy=0, done=0, err=0; all TVALID/TREADY outputs 0.
- Reset mid-frame aborts immediately; partial rows are discarded and not replayed.
- Routing is combinational pass-through of data and handshake (zero added latency). Only the state selects the path; unselected READY/VALID outputs are driven 0.
- A beat transfers when VALID&&READY on the active path.
- beat_cnt counts 0..WIDTH-1 per row transfer. Generated TLAST is 1 exactly at beat_cnt==WIDTH-1 on C_AXIS and M_AXIS, whatever the upstream TLAST.
- Upstream TLAST (S or R) != (beat_cnt==WIDTH-1) on a transfer sets err; the beat is still forwarded.
- States:
  - IDLE: start && !busy -> latch num_gens into gens_cfg; row_cnt=0; busy=1. Go to LOAD if gens_cfg!=0, else BYPASS.
  - LOAD: S->C. After beat WIDTH-1: gen_cnt=1; go to RECIRC if gens_cfg>1, else EMIT.
  - RECIRC: R->C. After beat WIDTH-1: gen_cnt++. When gen_cnt reaches gens_cfg-1 (pre-increment), go to EMIT.
  - EMIT: R->M. After beat WIDTH-1: row_cnt++. row_cnt==HEIGHT-1 -> FIN, else LOAD.
  - BYPASS: S->M, WIDTH beats per row, HEIGHT rows, then FIN.
  - FIN: done=1 for one cycle; busy=0; go to IDLE.
- Backpressure: any stall holds state and counters; the path never switches mid-row.
- start while busy: ignored, no effect on gens_cfg.
- gen_cnt is GEN_BITS wide and does not wrap: max gens_cfg = 2^GEN_BITS-1.
- Counter widths: beat_cnt = $clog2(WIDTH), row_cnt = $clog2(HEIGHT), each minimum 1.

Optional Feature:
- Macro: CONWARE_SCHED_STATS_EN.
- Defined: adds outputs stat_cycles[31:0] (cycles with busy=1 in the last frame) and stat_stalls[31:0] (busy cycles where the active path had VALID=1, READY=0).
  - Both clear on accepted start, freeze at FIN, saturate at 2^32-1, reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package conware_pkg holds:
  - state enum sched_state_t {IDLE, LOAD, RECIRC, EMIT, BYPASS, FIN};
  - localparams BEAT_W, ROW_W;
  - alive/dead colour constants 'h00FFFFFF / 'h00000000 used by core and bench.
- One sub-module: axis_beat_counter (WIDTH param; inputs fire and clear; outputs count and last_beat), instantiated once for beat_cnt.

Test Plan:
- WIDTH=4, HEIGHT=2, num_gens=0, seed rows A0..A3, B0..B3 -> M_AXIS gets the same 8 beats; TLAST on beats 3 and 7; done 1 cycle after beat 7; C_AXIS_TVALID never 1.
- num_gens=1, core model inverts colour -> each row: 4 beats S->C, then 4 beats R->M, no recirculation; M TLAST every 4th beat.
- num_gens=3 -> per row: C sees 12 beats (4 seed + 8 recirc); M sees 4 beats; done after row 2 emitted.
- Random M_AXIS_TREADY/S_AXIS_TVALID stalls (50%) with num_gens=2 -> output identical to no-stall run; no beats lost or duplicated.
- Seed TLAST driven at beat 2 of a 4-beat row -> err=1 and stays set; frame still completes; next start clears err.
- Assert ARESETN=0 mid-RECIRC -> next cycle busy=0, all VALID/READY 0; new start runs a full frame correctly.
